// File: rtl/prover_pkg.sv
// Shared definitions for the prover datapath: field width, shuffle FSM states, round-width helper.
// The OUTREG state exists only when PROVER_SHUFFLE_OUTREG_EN is defined.
`ifndef F_NBITS
`define F_NBITS 61
`endif

package prover_pkg;

    localparam int F_NBITS = `F_NBITS;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1
`ifdef PROVER_SHUFFLE_OUTREG_EN
        ,
        ST_OUTREG  = 2'd2
`endif
    } shuffle_state_t;

    // Bits needed to hold round values 0..nrounds; never narrower than one bit.
    function automatic int round_width(input int nrounds);
        return (nrounds < 1) ? 1 : $clog2(nrounds + 1);
    endfunction

endpackage

// File: rtl/prover_shuffle_v_mux.sv
// Per-gate selector: picks the captured pair value feeding gate gate_idx in the current round.
module prover_shuffle_v_mux
    import prover_pkg::*;
#(
    parameter int ngates_out = 4,
    parameter int gate_idx   = 0,
    parameter int rw         = 2
) (
    input  logic [F_NBITS-1:0] v_0 [ngates_out],
    input  logic [F_NBITS-1:0] v_1 [ngates_out],
    input  logic [F_NBITS-1:0] v_2 [ngates_out],
    input  logic [rw-1:0]      round,
    output logic [F_NBITS-1:0] s_0,
    output logic [F_NBITS-1:0] s_1,
    output logic [F_NBITS-1:0] s_2
);

    logic [31:0] idx;

    assign idx = 32'(gate_idx) >> (32'(round) + 32'd1);

    // A compare-and-select loop keeps every array access in range, even for
    // round codes the controller never produces.
    always_comb begin
        // NOTE: always_comb outputs get a default first so no path leaves them unassigned (no latch).
        s_0 = '0;
        s_1 = '0;
        s_2 = '0;
        for (int j = 0; j < ngates_out; j++) begin
            if (idx == 32'(j)) begin
                s_0 = v_0[j];
                s_1 = v_1[j];
                s_2 = v_2[j];
            end
        end
    end

endmodule

// File: rtl/prover_shuffle_v.sv
// Sumcheck layer shuffle: captures per-pair V evaluations and fans them out to every gate by round.
// Define PROVER_SHUFFLE_OUTREG_EN to add a registered output stage (latency 3 instead of 2).
module prover_shuffle_v
    import prover_pkg::*;
#(
    parameter  int ngates     = 8,
    localparam int nrounds    = $clog2(ngates),
    localparam int ngates_out = 1 << ($clog2(ngates) - 1),
    localparam int rw         = round_width(nrounds)
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               en,
    input  logic               restart,
    input  logic [F_NBITS-1:0] v_0 [ngates_out],
    input  logic [F_NBITS-1:0] v_1 [ngates_out],
    input  logic [F_NBITS-1:0] v_2 [ngates_out],
    output logic [F_NBITS-1:0] s_0 [ngates],
    output logic [F_NBITS-1:0] s_1 [ngates],
    output logic [F_NBITS-1:0] s_2 [ngates],
    output logic [rw-1:0]      round,
    output logic               ready,
    output logic               ready_pulse,
    output logic               last_round,
    output logic               err
);

    if (ngates < 2) begin : g_bad_ngates
        $error("prover_shuffle_v: ngates must be at least 2");
    end

    shuffle_state_t     state;
    logic               en_dly;
    logic               ready_dly;
    logic               start;
    logic [F_NBITS-1:0] cap_0 [ngates_out];
    logic [F_NBITS-1:0] cap_1 [ngates_out];
    logic [F_NBITS-1:0] cap_2 [ngates_out];
    logic [F_NBITS-1:0] mux_0 [ngates];
    logic [F_NBITS-1:0] mux_1 [ngates];
    logic [F_NBITS-1:0] mux_2 [ngates];

    assign start       = en & ~en_dly;
    assign ready       = (state == ST_IDLE) & ~start;
    assign ready_pulse = ready & ~ready_dly;
    assign last_round  = (round == rw'(nrounds - 1));

    // Both delay flops reset high so that neither an en already high nor the
    // idle state right after reset looks like a fresh edge.
    always_ff @(posedge clk or negedge rstb) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rstb) begin
            en_dly    <= 1'b1;
            ready_dly <= 1'b1;
        end else begin
            en_dly    <= en;
            ready_dly <= ready;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= ST_IDLE;
            round <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_CAPTURE;
                        if (restart) begin
                            round <= '0;
                            err   <= 1'b0;
                        end else if (last_round) begin
                            err   <= 1'b1;
                        end else begin
                            round <= round + 1'b1;
                        end
                    end
                end
`ifdef PROVER_SHUFFLE_OUTREG_EN
                ST_CAPTURE: state <= ST_OUTREG;
                ST_OUTREG:  state <= ST_IDLE;
`else
                ST_CAPTURE: state <= ST_IDLE;
`endif
                default:    state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        // NOTE: the captured arrays are plain flops, not RAM, so they take the reset like any other state.
        if (!rstb) begin
            for (int j = 0; j < ngates_out; j++) begin
                cap_0[j] <= '0;
                cap_1[j] <= '0;
                cap_2[j] <= '0;
            end
        end else if (state == ST_CAPTURE) begin
            for (int j = 0; j < ngates_out; j++) begin
                cap_0[j] <= v_0[j];
                cap_1[j] <= v_1[j];
                cap_2[j] <= v_2[j];
            end
        end
    end

    for (genvar g = 0; g < ngates; g++) begin : g_gate
        prover_shuffle_v_mux #(
            .ngates_out (ngates_out),
            .gate_idx   (g),
            .rw         (rw)
        ) u_mux (
            .v_0   (cap_0),
            .v_1   (cap_1),
            .v_2   (cap_2),
            .round (round),
            .s_0   (mux_0[g]),
            .s_1   (mux_1[g]),
            .s_2   (mux_2[g])
        );
    end

`ifdef PROVER_SHUFFLE_OUTREG_EN
    logic [F_NBITS-1:0] sreg_0 [ngates];
    logic [F_NBITS-1:0] sreg_1 [ngates];
    logic [F_NBITS-1:0] sreg_2 [ngates];

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < ngates; i++) begin
                sreg_0[i] <= '0;
                sreg_1[i] <= '0;
                sreg_2[i] <= '0;
            end
        end else if (state == ST_OUTREG) begin
            for (int i = 0; i < ngates; i++) begin
                sreg_0[i] <= mux_0[i];
                sreg_1[i] <= mux_1[i];
                sreg_2[i] <= mux_2[i];
            end
        end
    end

    assign s_0 = sreg_0;
    assign s_1 = sreg_1;
    assign s_2 = sreg_2;
`else
    assign s_0 = mux_0;
    assign s_1 = mux_1;
    assign s_2 = mux_2;
`endif

endmodule

// File: tb/tb_prover_shuffle_v.sv
// Self-checking bench for prover_shuffle_v (ngates=8): directed table, reset corner cases, random model.
// Expects latency 3 when PROVER_SHUFFLE_OUTREG_EN is defined, 2 otherwise.
module tb_prover_shuffle_v;
    import prover_pkg::*;

    localparam int NG = 8;
    localparam int NO = 4;
    localparam int NR = 3;
`ifdef PROVER_SHUFFLE_OUTREG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    typedef logic [F_NBITS-1:0] fv_t;
    typedef fv_t vin_t  [3][NO];
    typedef fv_t sout_t [3][NG];

    typedef struct {
        bit    rs;
        vin_t  v;
        int    exp_round;
        bit    exp_err;
        bit    exp_last;
        sout_t s;
    } vec_t;

    logic       clk = 1'b0;
    logic       rstb;
    logic       en;
    logic       restart;
    fv_t        v0 [NO];
    fv_t        v1 [NO];
    fv_t        v2 [NO];
    fv_t        s0 [NG];
    fv_t        s1 [NG];
    fv_t        s2 [NG];
    logic [1:0] round;
    logic       ready;
    logic       ready_pulse;
    logic       last_round;
    logic       err;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int   m_round;
    bit   m_err;
    vin_t m_v;

    always #5 clk = ~clk;

    prover_shuffle_v #(.ngates(NG)) dut (
        .clk         (clk),
        .rstb        (rstb),
        .en          (en),
        .restart     (restart),
        .v_0         (v0),
        .v_1         (v1),
        .v_2         (v2),
        .s_0         (s0),
        .s_1         (s1),
        .s_2         (s2),
        .round       (round),
        .ready       (ready),
        .ready_pulse (ready_pulse),
        .last_round  (last_round),
        .err         (err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic fv_t rnd_f();
        return fv_t'({$urandom(), $urandom()});
    endfunction

    task automatic drive_v(input vin_t nv);
        for (int j = 0; j < NO; j++) begin
            v0[j] = nv[0][j];
            v1[j] = nv[1][j];
            v2[j] = nv[2][j];
        end
    endtask

    task automatic scramble_v();
        for (int j = 0; j < NO; j++) begin
            v0[j] = rnd_f();
            v1[j] = rnd_f();
            v2[j] = rnd_f();
        end
    endtask

    task automatic check_s(input string tag, input sout_t exp);
        for (int i = 0; i < NG; i++) begin
            check($sformatf("%s s_0[%0d]", tag, i), 64'(s0[i]), 64'(exp[0][i]));
            check($sformatf("%s s_1[%0d]", tag, i), 64'(s1[i]), 64'(exp[1][i]));
            check($sformatf("%s s_2[%0d]", tag, i), 64'(s2[i]), 64'(exp[2][i]));
        end
    endtask

    // Junk on v in the start cycle, real data only while the block captures,
    // junk again afterwards; returns at the negedge where ready is seen.
    task automatic run_shuffle(input bit rs, input vin_t nv, output int lat);
        @(negedge clk);
        en = 1'b1;
        restart = rs;
        scramble_v();
        @(negedge clk);
        en = 1'b0;
        restart = 1'($urandom());
        drive_v(nv);
        lat = 1;
        while (!ready && lat < 10) begin
            @(negedge clk);
            lat++;
            scramble_v();
        end
    endtask

    task automatic shuffle_and_check(input string tag, input bit rs, input vin_t nv,
                                     input int exp_round, input bit exp_err, input bit exp_last,
                                     input sout_t exp_s);
        int lat;
        run_shuffle(rs, nv, lat);
        check({tag, " latency"}, 64'(lat), 64'(LAT));
        check({tag, " ready_pulse"}, 64'(ready_pulse), 64'd1);
        check({tag, " round"}, 64'(round), 64'(exp_round));
        check({tag, " err"}, 64'(err), 64'(exp_err));
        check({tag, " last_round"}, 64'(last_round), 64'(exp_last));
        check_s(tag, exp_s);
        @(negedge clk);
        check({tag, " pulse_off"}, 64'(ready_pulse), 64'd0);
        check_s({tag, " hold"}, exp_s);
    endtask

    // Model: on start, apply the round rule; gate i of round r reads pair i / 2^(r+1).
    task automatic model_start(input bit rs, input vin_t nv);
        if (rs) begin
            m_round = 0;
            m_err = 1'b0;
        end else if (m_round == NR - 1) begin
            m_err = 1'b1;
        end else begin
            m_round = m_round + 1;
        end
        m_v = nv;
    endtask

    function automatic sout_t model_s();
        sout_t r;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < NG; i++)
                r[k][i] = m_v[k][i / (2 ** (m_round + 1))];
        return r;
    endfunction

    vec_t  tbl [5];
    vin_t  nv;
    sout_t zero_s;
    int    lat;

    initial begin
        // Directed vectors: the documented sequence 10/20/30, then overflow and restart.
        for (int e = 0; e < 3; e++) begin
            tbl[e].v[0] = '{10, 11, 12, 13};
            tbl[e].v[1] = '{20, 21, 22, 23};
            tbl[e].v[2] = '{30, 31, 32, 33};
        end
        for (int e = 3; e < 5; e++) begin
            tbl[e].v[0] = '{50, 51, 52, 53};
            tbl[e].v[1] = '{60, 61, 62, 63};
            tbl[e].v[2] = '{70, 71, 72, 73};
        end
        tbl[0].rs = 1; tbl[0].exp_round = 0; tbl[0].exp_err = 0; tbl[0].exp_last = 0;
        tbl[0].s[0] = '{10, 10, 11, 11, 12, 12, 13, 13};
        tbl[0].s[1] = '{20, 20, 21, 21, 22, 22, 23, 23};
        tbl[0].s[2] = '{30, 30, 31, 31, 32, 32, 33, 33};
        tbl[1].rs = 0; tbl[1].exp_round = 1; tbl[1].exp_err = 0; tbl[1].exp_last = 0;
        tbl[1].s[0] = '{10, 10, 10, 10, 11, 11, 11, 11};
        tbl[1].s[1] = '{20, 20, 20, 20, 21, 21, 21, 21};
        tbl[1].s[2] = '{30, 30, 30, 30, 31, 31, 31, 31};
        tbl[2].rs = 0; tbl[2].exp_round = 2; tbl[2].exp_err = 0; tbl[2].exp_last = 1;
        tbl[2].s[0] = '{10, 10, 10, 10, 10, 10, 10, 10};
        tbl[2].s[1] = '{20, 20, 20, 20, 20, 20, 20, 20};
        tbl[2].s[2] = '{30, 30, 30, 30, 30, 30, 30, 30};
        tbl[3].rs = 0; tbl[3].exp_round = 2; tbl[3].exp_err = 1; tbl[3].exp_last = 1;
        tbl[3].s[0] = '{50, 50, 50, 50, 50, 50, 50, 50};
        tbl[3].s[1] = '{60, 60, 60, 60, 60, 60, 60, 60};
        tbl[3].s[2] = '{70, 70, 70, 70, 70, 70, 70, 70};
        tbl[4].rs = 1; tbl[4].exp_round = 0; tbl[4].exp_err = 0; tbl[4].exp_last = 0;
        tbl[4].s[0] = '{50, 50, 51, 51, 52, 52, 53, 53};
        tbl[4].s[1] = '{60, 60, 61, 61, 62, 62, 63, 63};
        tbl[4].s[2] = '{70, 70, 71, 71, 72, 72, 73, 73};
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < NG; i++)
                zero_s[k][i] = '0;

        // Power-up reset
        rstb = 1'b0;
        en = 1'b0;
        restart = 1'b0;
        scramble_v();
        repeat (2) @(negedge clk);
        check("reset round", 64'(round), 64'd0);
        check("reset err", 64'(err), 64'd0);
        check("reset ready", 64'(ready), 64'd1);
        check("reset ready_pulse", 64'(ready_pulse), 64'd0);
        check_s("reset", zero_s);
        rstb = 1'b1;
        @(negedge clk);
        check("post-reset ready_pulse", 64'(ready_pulse), 64'd0);

        for (int e = 0; e < 5; e++)
            shuffle_and_check($sformatf("vec%0d", e), tbl[e].rs, tbl[e].v, tbl[e].exp_round,
                              tbl[e].exp_err, tbl[e].exp_last, tbl[e].s);
        m_round = 0;
        m_err = 1'b0;
        m_v = tbl[4].v;

        // en held high through and after busy: only the one rising edge counts.
        for (int j = 0; j < NO; j++) begin
            nv[0][j] = rnd_f();
            nv[1][j] = rnd_f();
            nv[2][j] = rnd_f();
        end
        @(negedge clk);
        en = 1'b1;
        restart = 1'b0;
        drive_v(nv);
        repeat (6) @(negedge clk);
        model_start(1'b0, nv);
        check("held-en round", 64'(round), 64'(m_round));
        check("held-en ready", 64'(ready), 64'd1);
        check_s("held-en", model_s());
        en = 1'b0;
        @(negedge clk);

        // Asynchronous reset while capturing aborts everything.
        en = 1'b1;
        restart = 1'b1;
        @(negedge clk);
        en = 1'b0;
        rstb = 1'b0;
        #1;
        check("abort round", 64'(round), 64'd0);
        check("abort err", 64'(err), 64'd0);
        check("abort ready", 64'(ready), 64'd1);
        check("abort last_round", 64'(last_round), 64'd0);
        check_s("abort", zero_s);
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        check("abort release pulse", 64'(ready_pulse), 64'd0);
        @(negedge clk);
        check("abort release pulse2", 64'(ready_pulse), 64'd0);
        m_round = 0;
        m_err = 1'b0;
        for (int j = 0; j < NO; j++) begin
            nv[0][j] = rnd_f();
            nv[1][j] = rnd_f();
            nv[2][j] = rnd_f();
        end
        model_start(1'b0, nv);
        shuffle_and_check("after-abort", 1'b0, nv, m_round, m_err, m_round == NR - 1, model_s());

        // Random shuffles against the model
        for (int t = 0; t < 40; t++) begin
            bit rs;
            rs = ($urandom_range(3) == 0);
            for (int j = 0; j < NO; j++) begin
                nv[0][j] = rnd_f();
                nv[1][j] = rnd_f();
                nv[2][j] = rnd_f();
            end
            model_start(rs, nv);
            shuffle_and_check($sformatf("rand%0d", t), rs, nv, m_round, m_err,
                              m_round == NR - 1, model_s());
            repeat ($urandom_range(2)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/prover_shuffle_v.md
PROVER_SHUFFLE_V -- requirements
Module: prover_shuffle_v

Interface
REQ-001 SHALL have parameter ngates, default 8, number of layer input gates (>=2).
REQ-002 SHALL have derived parameter ngates_out = 1 << ($clog2(ngates)-1) and nrounds = $clog2(ngates); overriding either SHALL raise an elaboration error.
REQ-003 SHALL have port clk  input  1  clock; reset rstb, asynchronous, active-low; clock clk.
REQ-004 SHALL have port rstb  input  1  asynchronous active-low reset.
REQ-005 SHALL have port en  input  1  level enable; rising edge starts one shuffle.
REQ-006 SHALL have port restart  input  1  sampled at start; 1 = first sumcheck round of a layer.
REQ-007 SHALL have ports v_0, v_1, v_2  input  [F_NBITS-1:0] x ngates_out  upstream V(0), V(1), V(2) evaluations per pair.
REQ-008 SHALL have ports s_0, s_1, s_2  output  [F_NBITS-1:0] x ngates  per-gate shuffled evaluations.
REQ-009 SHALL have port round  output  [$clog2(nrounds+1)-1:0]  current round index.
REQ-010 SHALL have ports ready, ready_pulse  output  1  idle, and single-cycle rising edge of ready.
REQ-011 SHALL have port last_round  output  1  round == nrounds-1.
REQ-012 SHALL have port err  output  1  sticky round-overflow flag.

Function
REQ-013 SHALL detect start = en & ~en_dly; ready = (state==IDLE) & ~start; ready_pulse = ready & ~ready_dly.
REQ-014 SHALL implement states IDLE -> CAPTURE -> (OUTREG if enabled) -> IDLE, one cycle each.
REQ-015 On start with restart=1, round SHALL load 0 and err SHALL clear.
REQ-016 On start with restart=0, round SHALL increment by 1; if round == nrounds-1 already, round SHALL hold and err SHALL set.
REQ-017 In CAPTURE, v_0/v_1/v_2 SHALL be registered internally; start-cycle input values are don't-care.
REQ-018 For every gate i: s_k[i] SHALL equal captured v_k[i >> (round+1)], k in {0,1,2}, using the updated round.
REQ-019 Indices i >> (round+1) SHALL always be < ngates_out; no out-of-range selection SHALL exist.
REQ-020 Outputs s_k SHALL hold stable between shuffles; latency start -> ready = 2 cycles (3 with REQ-025).
REQ-021 start while not IDLE SHALL be impossible by construction (ready low); en edges during busy SHALL be ignored until IDLE.
REQ-022 last_round SHALL be combinational from round.

Reset
REQ-023 On rstb low: state IDLE, round 0, err 0, all captured and s_k registers 0, en_dly 1, ready_dly 1 (no spurious ready_pulse after reset).
REQ-024 Reset mid-operation SHALL abort immediately; next start SHALL behave as after power-up.

Configuration
REQ-025 Macro PROVER_SHUFFLE_OUTREG_EN defined: s_k SHALL come from an extra output register stage (state OUTREG), latency 3; undefined: s_k SHALL be the combinational mux of captured values, latency 2, no OUTREG state.

Structure
REQ-026 State enum and round-width function SHALL live in shared package prover_pkg; F_NBITS SHALL come from field arithmetic defines.
REQ-027 Per-gate selection SHALL be sub-module prover_shuffle_v_mux (inputs: three ngates_out arrays, round, gate index parameter; outputs three values), instantiated ngates times.

Verification (ngates=8, ngates_out=4, nrounds=3)
REQ-028 Reset, then en rise with restart=1, v_0={10,11,12,13} -> after 2 cycles ready=1, round=0, s_0={10,10,11,11,12,12,13,13}, ready_pulse one cycle.
REQ-029 Next en rise restart=0, v_1={20,21,22,23} -> round=1, s_1={20,20,20,20,21,21,21,21}.
REQ-030 Third en rise restart=0, v_2={30,31,32,33} -> round=2, last_round=1, s_2 all 30.
REQ-031 Fourth en rise restart=0 -> round stays 2, err=1; then restart=1 -> round=0, err=0.
REQ-032 Assert rstb mid-CAPTURE -> all outputs 0, ready=1, no ready_pulse in cycle after release.
REQ-033 Repeat REQ-028 with PROVER_SHUFFLE_OUTREG_EN defined -> identical values, ready after 3 cycles.
